regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp_if.sv | 34 +++
 rtl/regfile_mp.sv | 141 ++++++++++++++
 tb/tb_regfile_mp.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: read ports, two write ports,
// reserve strobe, clear sweep control and the pending scoreboard.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [NUM_RD-1:0]        in_rd_ena;
  logic [NUM_RD*ADDR_W-1:0] in_rd_addr;
  logic [NUM_RD*DATA_W-1:0] out_rd_data;
  logic [NUM_RD-1:0]        out_rd_pend;
  logic [1:0]               in_wr_ena;
  logic [2*ADDR_W-1:0]      in_wr_addr;
  logic [2*DATA_W-1:0]      in_wr_data;
  logic                     in_rsv_ena;
  logic [ADDR_W-1:0]        in_rsv_addr;
  logic                     in_clr;
  logic                     out_clr_busy;
  logic [DEPTH-1:0]         out_pend_vec;

  modport slave (
    input  in_rd_ena, in_rd_addr, in_wr_ena, in_wr_addr, in_wr_data,
           in_rsv_ena, in_rsv_addr, in_clr,
    output out_rd_data, out_rd_pend, out_clr_busy, out_pend_vec
  );

  modport master (
    output in_rd_ena, in_rd_addr, in_wr_ena, in_wr_addr, in_wr_data,
           in_rsv_ena, in_rsv_addr, in_clr,
    input  out_rd_data, out_rd_pend, out_clr_busy, out_pend_vec
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with write-through reads, a pending
// scoreboard and a one-register-per-cycle clear sweep. Register 0 reads as zero.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input logic          in_clk,
  input logic          in_rst_n,
  regfile_mp_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0]        mem_r [DEPTH];
  logic [DEPTH-1:0]         pend_r;
  logic [DEPTH-1:0]         pend_nxt_s;
  logic [0:0]               state_r;
  logic [ADDR_W-1:0]        cnt_r;
  logic [NUM_RD*DATA_W-1:0] rd_data_r;
  logic [NUM_RD*DATA_W-1:0] rd_data_s;
  logic [NUM_RD-1:0]        rd_pend_r;
  logic [NUM_RD-1:0]        rd_pend_s;
  logic [ADDR_W-1:0]        ra_s;
  logic                     hit0_s;
  logic                     hit1_s;

  logic              idle_s;
  logic              wen0_s;
  logic              wen1_s;
  logic              rsv_s;
  logic [ADDR_W-1:0] wa0_s;
  logic [ADDR_W-1:0] wa1_s;
  logic [DATA_W-1:0] wd0_s;
  logic [DATA_W-1:0] wd1_s;

  // Writes and reservations only take effect in IDLE and never to address 0.
  assign idle_s = (state_r == ST_IDLE);
  assign wa0_s  = bus.in_wr_addr[0 +: ADDR_W];
  assign wa1_s  = bus.in_wr_addr[ADDR_W +: ADDR_W];
  assign wd0_s  = bus.in_wr_data[0 +: DATA_W];
  assign wd1_s  = bus.in_wr_data[DATA_W +: DATA_W];
  assign wen0_s = idle_s && bus.in_wr_ena[0] && (wa0_s != ADDR_ZERO);
  assign wen1_s = idle_s && bus.in_wr_ena[1] && (wa1_s != ADDR_ZERO);
  assign rsv_s  = idle_s && bus.in_rsv_ena && (bus.in_rsv_addr != ADDR_ZERO);

  // Scoreboard next state: reserve beats a same-cycle write; sweep clears one bit per cycle.
  always_comb begin
    pend_nxt_s = pend_r;
    for (int n = 0; n < DEPTH; n++) begin
      if (idle_s) begin
        pend_nxt_s[n] = (rsv_s && (bus.in_rsv_addr == ADDR_W'(n))) ||
                        (pend_r[n] && !(wen0_s && (wa0_s == ADDR_W'(n)))
                                   && !(wen1_s && (wa1_s == ADDR_W'(n))));
      end else begin
        pend_nxt_s[n] = pend_r[n] && (cnt_r != ADDR_W'(n));
      end
    end
    pend_nxt_s[0] = 1'b0;
  end

  // Read path with write-through bypass, port 1 having priority over port 0.
  always_comb begin
    rd_data_s = '0;
    rd_pend_s = '0;
    ra_s      = '0;
    hit0_s    = 1'b0;
    hit1_s    = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra_s   = bus.in_rd_addr[i*ADDR_W +: ADDR_W];
      hit0_s = wen0_s && (wa0_s == ra_s);
      hit1_s = wen1_s && (wa1_s == ra_s);
      if (!bus.in_rd_ena[i] || (ra_s == ADDR_ZERO) || !idle_s) begin
        rd_data_s[i*DATA_W +: DATA_W] = '0;
        rd_pend_s[i]                  = 1'b0;
      end else begin
        if (hit1_s) begin
          rd_data_s[i*DATA_W +: DATA_W] = wd1_s;
        end else if (hit0_s) begin
          rd_data_s[i*DATA_W +: DATA_W] = wd0_s;
        end else begin
          rd_data_s[i*DATA_W +: DATA_W] = mem_r[ra_s];
        end
        rd_pend_s[i] = (pend_r[ra_s] && !hit0_s && !hit1_s) ||
                       (rsv_s && (bus.in_rsv_addr == ra_s));
      end
    end
  end

  // Storage, scoreboard, sweep FSM and registered read outputs.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int n = 0; n < DEPTH; n++) begin
        mem_r[n] <= '0;
      end
      pend_r    <= '0;
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      rd_data_r <= '0;
      rd_pend_r <= '0;
    end else begin
      pend_r    <= pend_nxt_s;
      rd_data_r <= rd_data_s;
      rd_pend_r <= rd_pend_s;
      case (state_r)
        ST_IDLE: begin
          if (wen0_s) begin
            mem_r[wa0_s] <= wd0_s;
          end
          if (wen1_s) begin
            mem_r[wa1_s] <= wd1_s;
          end
          if (bus.in_clr) begin
            state_r <= ST_SWEEP;
            cnt_r   <= ADDR_ONE;
          end
        end
        ST_SWEEP: begin
          mem_r[cnt_r] <= '0;
          cnt_r        <= cnt_r + ADDR_ONE;
          if (cnt_r == ADDR_LAST) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign bus.out_rd_data  = rd_data_r;
  assign bus.out_rd_pend  = rd_pend_r;
  assign bus.out_clr_busy = (state_r == ST_SWEEP);
  assign bus.out_pend_vec = pend_r;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: an array-based reference model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) rif ();
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .in_clk(clk), .in_rst_n(rst_n), .bus(rif)
  );

  int n_checks = 0;
  int n_err = 0;

  logic [DW-1:0]    m_mem [DEPTH];
  logic [DEPTH-1:0] m_pend;
  int               m_left;
  int               m_idx;
  logic [DW-1:0]    e_data [NR];
  logic [NR-1:0]    e_pend;
  logic             e_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rif.in_rd_ena = '0; rif.in_rd_addr = '0;
    rif.in_wr_ena = '0; rif.in_wr_addr = '0; rif.in_wr_data = '0;
    rif.in_rsv_ena = 1'b0; rif.in_rsv_addr = '0; rif.in_clr = 1'b0;
  endtask

  task automatic wr(input int p, input int a, input logic [DW-1:0] d);
    rif.in_wr_ena[p] = 1'b1;
    rif.in_wr_addr[p*AW +: AW] = AW'(a);
    rif.in_wr_data[p*DW +: DW] = d;
  endtask

  task automatic rd(input int p, input int a);
    rif.in_rd_ena[p] = 1'b1;
    rif.in_rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic rsv(input int a);
    rif.in_rsv_ena = 1'b1;
    rif.in_rsv_addr = AW'(a);
  endtask

  task automatic model_reset();
    for (int n = 0; n < DEPTH; n++) m_mem[n] = '0;
    m_pend = '0; m_left = 0; m_idx = 0; e_busy = 1'b0; e_pend = '0;
    for (int i = 0; i < NR; i++) e_data[i] = '0;
  endtask

  // Reference behaviour for one rising edge, from the current inputs.
  task automatic model_step();
    bit busy_now, we0, we1, rs;
    int wa0, wa1, ar, ra;
    logic [DW-1:0] wd0, wd1;
    busy_now = (m_left > 0);
    wa0 = int'(rif.in_wr_addr[0 +: AW]);  wa1 = int'(rif.in_wr_addr[AW +: AW]);
    wd0 = rif.in_wr_data[0 +: DW];        wd1 = rif.in_wr_data[DW +: DW];
    ar  = int'(rif.in_rsv_addr);
    we0 = rif.in_wr_ena[0] && wa0 != 0 && !busy_now;
    we1 = rif.in_wr_ena[1] && wa1 != 0 && !busy_now;
    rs  = rif.in_rsv_ena && ar != 0 && !busy_now;
    for (int i = 0; i < NR; i++) begin
      ra = int'(rif.in_rd_addr[i*AW +: AW]);
      if (!rif.in_rd_ena[i] || ra == 0 || busy_now) begin
        e_data[i] = '0; e_pend[i] = 1'b0;
      end else begin
        if (we1 && wa1 == ra) e_data[i] = wd1;
        else if (we0 && wa0 == ra) e_data[i] = wd0;
        else e_data[i] = m_mem[ra];
        e_pend[i] = (m_pend[ra] && !(we0 && wa0 == ra) && !(we1 && wa1 == ra)) || (rs && ar == ra);
      end
    end
    if (busy_now) begin
      m_mem[m_idx] = '0; m_pend[m_idx] = 1'b0; m_idx++; m_left--;
    end else begin
      if (we0) begin m_mem[wa0] = wd0; m_pend[wa0] = 1'b0; end
      if (we1) begin m_mem[wa1] = wd1; m_pend[wa1] = 1'b0; end
      if (rs) m_pend[ar] = 1'b1;
      if (rif.in_clr) begin m_left = DEPTH - 1; m_idx = 1; end
    end
    e_busy = (m_left > 0);
  endtask

  task automatic compare();
    for (int i = 0; i < NR; i++) begin
      check($sformatf("rd_data[%0d]", i), 64'(rif.out_rd_data[i*DW +: DW]), 64'(e_data[i]));
      check($sformatf("rd_pend[%0d]", i), 64'(rif.out_rd_pend[i]), 64'(e_pend[i]));
    end
    check("clr_busy", 64'(rif.out_clr_busy), 64'(e_busy));
    check("pend_vec", 64'(rif.out_pend_vec), 64'(m_pend));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare();
    idle_inputs();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_data"}, 64'(rif.out_rd_data), 64'h0);
    check({tag, "_rd_pend"}, 64'(rif.out_rd_pend), 64'h0);
    check({tag, "_busy"}, 64'(rif.out_clr_busy), 64'h0);
    check({tag, "_pend_vec"}, 64'(rif.out_pend_vec), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    #2 rst_n = 1'b1;

    // Write then read back on the following cycle.
    wr(0, 3, 32'h0000_1234);
    cycle();
    rd(0, 3);
    cycle();
    check("wr_rd_data", 64'(rif.out_rd_data[31:0]), 64'h1234);
    check("wr_rd_pend", 64'(rif.out_rd_pend[0]), 64'h0);

    // Dual write to one address: port 1 wins both on bypass and in storage.
    wr(0, 7, 32'h0000_000A); wr(1, 7, 32'h0000_000B); rd(0, 7);
    cycle();
    check("dual_bypass", 64'(rif.out_rd_data[31:0]), 64'hB);
    rd(1, 7);
    cycle();
    check("dual_stored", 64'(rif.out_rd_data[63:32]), 64'hB);

    // Scoreboard set, observed, cleared by write, and held by reserve+write.
    rsv(5);
    cycle();
    check("rsv_vec", 64'(rif.out_pend_vec[5]), 64'h1);
    rd(0, 5);
    cycle();
    check("rsv_rd_pend", 64'(rif.out_rd_pend[0]), 64'h1);
    wr(0, 5, 32'h0000_0055);
    cycle();
    check("wr_clears", 64'(rif.out_pend_vec[5]), 64'h0);
    rsv(5); wr(1, 5, 32'h0000_0066); rd(1, 5);
    cycle();
    check("rsv_wr_vec", 64'(rif.out_pend_vec[5]), 64'h1);
    check("rsv_wr_rdpend", 64'(rif.out_rd_pend[1]), 64'h1);
    check("rsv_wr_data", 64'(rif.out_rd_data[63:32]), 64'h66);

    // Register 0 is immutable.
    wr(0, 0, 32'hFFFF_FFFF); rsv(0);
    cycle();
    rd(0, 0); rd(1, 0);
    cycle();
    check("r0_data", 64'(rif.out_rd_data), 64'h0);
    check("r0_pend", 64'(rif.out_rd_pend), 64'h0);
    check("r0_vec", 64'(rif.out_pend_vec[0]), 64'h0);

    // Fill every register, reserving some, then sweep.
    for (int a = 1; a < DEPTH; a += 2) begin
      wr(0, a, 32'hA5A5_0000 | a);
      if (a + 1 < DEPTH) wr(1, a + 1, 32'h5A5A_0000 | (a + 1));
      if (a % 4 == 1) rsv(a);
      cycle();
    end
    rd(0, 9); rd(1, 20);
    cycle();
    check("fill_rd9", 64'(rif.out_rd_data[31:0]), 64'hA5A5_0009);
    check("fill_rd20", 64'(rif.out_rd_data[63:32]), 64'h5A5A_0014);
    wr(0, 4, 32'hDEAD_BEEF); rif.in_clr = 1'b1;
    cycle();
    busy_cnt = 0;
    for (int k = 0; k < 40 && rif.out_clr_busy; k++) begin
      busy_cnt++;
      wr(0, (k % 31) + 1, 32'h1111_0000 | k); wr(1, 4, 32'h2222_2222);
      rsv((k % 31) + 1); rd(0, 4); rd(1, (k % 31) + 1); rif.in_clr = 1'b1;
      cycle();
    end
    check("busy_cycles", 64'(busy_cnt), 64'd31);
    for (int a = 0; a < DEPTH; a += 2) begin
      rd(0, a); rd(1, a + 1);
      cycle();
    end
    check("sweep_vec", 64'(rif.out_pend_vec), 64'h0);

    // Reset in the middle of a sweep with a write pending.
    wr(0, 10, 32'h0000_0010); wr(1, 11, 32'h0000_0011); rsv(12);
    cycle();
    rif.in_clr = 1'b1;
    cycle();
    repeat (5) begin
      wr(0, 13, 32'h0000_0013);
      cycle();
    end
    wr(0, 14, 32'h0000_0014); rd(0, 12);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst_sweep");
    model_reset();
    idle_inputs();
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a += 2) begin
      rd(0, a); rd(1, a + 1);
      cycle();
    end
    check("post_rst_busy", 64'(rif.out_clr_busy), 64'h0);

    // Reset while read data is live, then confirm storage was cleared.
    wr(0, 20, 32'h0000_0077);
    cycle();
    rd(0, 20); rsv(21);
    cycle();
    check("live_data", 64'(rif.out_rd_data[31:0]), 64'h77);
    check("live_vec", 64'(rif.out_pend_vec), 64'h0020_0000);
    wr(1, 22, 32'h0000_0088); rd(0, 20);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst_live");
    model_reset();
    idle_inputs();
    @(posedge clk);
    #3 rst_n = 1'b1;
    rd(0, 20); rd(1, 22);
    cycle();
    check("rst_cleared", 64'(rif.out_rd_data), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
